// File: rtl/rf_pkg.sv
// Shared constants and the byte-merge helper for the register file.
// merge_bytes works on a fixed maximum width; callers zero-extend their operands and truncate the result.
package rf_pkg;

   localparam int RF_WIDTH     = 32;
   localparam int RF_DEPTH     = 32;
   localparam int RF_ADDR_W    = $clog2(RF_DEPTH);
   localparam int RF_BE_W      = RF_WIDTH / 8;
   localparam int RF_MAX_WIDTH = 256;
   localparam int RF_MAX_BE    = RF_MAX_WIDTH / 8;

   // Each byte of the result comes from new_data where be is set, else from old_data.
   function automatic logic [RF_MAX_WIDTH-1:0] merge_bytes(
      input logic [RF_MAX_WIDTH-1:0] old_data,
      input logic [RF_MAX_WIDTH-1:0] new_data,
      input logic [RF_MAX_BE-1:0]    be
   );
      logic [RF_MAX_WIDTH-1:0] merged;
      merged = old_data;
      for (int i = 0; i < RF_MAX_BE; i++) begin
         if (be[i]) merged[8*i +: 8] = new_data[8*i +: 8];
      end
      return merged;
   endfunction

endpackage

// File: rtl/n_bit_reg_file_if.sv
// Write port and two read ports of the register file, grouped as one bus.
// Handshake: none; a write is taken on every rising clk edge where we=1, reads are combinational.
interface n_bit_reg_file_if #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 32
);
   localparam int ADDR_W = $clog2(DEPTH);
   localparam int BE_W   = WIDTH / 8;

   logic              we;
   logic [ADDR_W-1:0] waddr;
   logic [BE_W-1:0]   wbe;
   logic [WIDTH-1:0]  wdata;
   logic [ADDR_W-1:0] raddr_a;
   logic [ADDR_W-1:0] raddr_b;
   logic [WIDTH-1:0]  rdata_a;
   logic [WIDTH-1:0]  rdata_b;

   modport master (
      output we, waddr, wbe, wdata, raddr_a, raddr_b,
      input  rdata_a, rdata_b
   );

   modport slave (
      input  we, waddr, wbe, wdata, raddr_a, raddr_b,
      output rdata_a, rdata_b
   );
endinterface

// File: rtl/rf_entry.sv
// One register-file entry: WIDTH flops with per-byte load enables and asynchronous active-low clear.
module rf_entry
   import rf_pkg::*;
#(
   parameter int WIDTH = RF_WIDTH
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [WIDTH/8-1:0] be,
   input  logic [WIDTH-1:0]   d,
   output logic [WIDTH-1:0]   q
);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         q <= '0;
      end else begin
         for (int i = 0; i < WIDTH / 8; i++) begin
            if (be[i]) q[8*i +: 8] <= d[8*i +: 8];
         end
      end
   end

endmodule

// File: rtl/n_bit_reg_file.sv
// Architectural register file: one byte-enabled write port, two combinational read ports,
// optional hard-wired zero entry and optional same-cycle write-to-read bypass.
module n_bit_reg_file
   import rf_pkg::*;
#(
   parameter int WIDTH    = RF_WIDTH,
   parameter int DEPTH    = RF_DEPTH,
   parameter bit ZERO_REG = 1'b1,
   parameter bit BYPASS   = 1'b1
) (
   input logic              clk,
   input logic              rst,
   n_bit_reg_file_if.slave  bus
);

   localparam int ADDR_W = $clog2(DEPTH);
   localparam int BE_W   = WIDTH / 8;

   logic [WIDTH-1:0] entry_q [DEPTH];

   for (genvar e = 0; e < DEPTH; e++) begin : g_entry
      if (ZERO_REG && e == 0) begin : g_zero
         assign entry_q[e] = '0;
      end else begin : g_reg
         logic [BE_W-1:0] be_e;
         assign be_e = (bus.we && bus.waddr == ADDR_W'(e)) ? bus.wbe : '0;
         rf_entry #(.WIDTH(WIDTH)) u_entry (
            .clk (clk),
            .rst (rst),
            .be  (be_e),
            .d   (bus.wdata),
            .q   (entry_q[e])
         );
      end
   end

   // Reset forces zero on both ports, which also blocks a bypass of a write held during reset.
   logic [WIDTH-1:0] stored_a, stored_b;
   logic             zero_a, zero_b, hit_a, hit_b;

   assign stored_a = entry_q[bus.raddr_a];
   assign stored_b = entry_q[bus.raddr_b];
   assign zero_a   = !rst || (ZERO_REG && bus.raddr_a == '0);
   assign zero_b   = !rst || (ZERO_REG && bus.raddr_b == '0);
   assign hit_a    = BYPASS && bus.we && (bus.raddr_a == bus.waddr);
   assign hit_b    = BYPASS && bus.we && (bus.raddr_b == bus.waddr);

   always_comb begin
      bus.rdata_a = stored_a;
      if (zero_a) begin
         bus.rdata_a = '0;
      end else if (hit_a) begin
         bus.rdata_a = WIDTH'(merge_bytes(RF_MAX_WIDTH'(stored_a), RF_MAX_WIDTH'(bus.wdata),
                                          RF_MAX_BE'(bus.wbe)));
      end
   end

   always_comb begin
      bus.rdata_b = stored_b;
      if (zero_b) begin
         bus.rdata_b = '0;
      end else if (hit_b) begin
         bus.rdata_b = WIDTH'(merge_bytes(RF_MAX_WIDTH'(stored_b), RF_MAX_WIDTH'(bus.wdata),
                                          RF_MAX_BE'(bus.wbe)));
      end
   end

endmodule

// File: tb/tb_n_bit_reg_file.sv
// Bench for n_bit_reg_file: a ZERO_REG=1/BYPASS=1 instance (m) and a ZERO_REG=0/BYPASS=0 instance (s)
// driven with identical stimulus and compared against per-instance array models.
module tb_n_bit_reg_file;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   checks = 0;
   int   failures = 0;

   logic [31:0] mem_m [32];
   logic [31:0] mem_s [32];
   logic [31:0] exp_q [$];

   typedef struct {
      logic        we;
      logic [4:0]  waddr;
      logic [3:0]  wbe;
      logic [31:0] wdata;
      logic [4:0]  ra;
      logic [4:0]  rb;
      logic [31:0] exp_ma;
      logic [31:0] exp_mb;
      logic [31:0] exp_sa;
      logic [31:0] exp_sb;
   } vec_t;

   vec_t vecs [8];

   n_bit_reg_file_if #(.WIDTH(32), .DEPTH(32)) bus_m ();
   n_bit_reg_file_if #(.WIDTH(32), .DEPTH(32)) bus_s ();

   n_bit_reg_file #(.WIDTH(32), .DEPTH(32), .ZERO_REG(1'b1), .BYPASS(1'b1)) dut_m (
      .clk (clk),
      .rst (rst),
      .bus (bus_m)
   );

   n_bit_reg_file #(.WIDTH(32), .DEPTH(32), .ZERO_REG(1'b0), .BYPASS(1'b0)) dut_s (
      .clk (clk),
      .rst (rst),
      .bus (bus_s)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   task automatic assert_reset();
      rst = 1'b0;
      for (int i = 0; i < 32; i++) begin
         mem_m[i] = '0;
         mem_s[i] = '0;
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic drive(input logic we, input logic [4:0] waddr, input logic [3:0] wbe,
                        input logic [31:0] wdata, input logic [4:0] ra, input logic [4:0] rb);
      bus_m.we = we; bus_m.waddr = waddr; bus_m.wbe = wbe; bus_m.wdata = wdata;
      bus_m.raddr_a = ra; bus_m.raddr_b = rb;
      bus_s.we = we; bus_s.waddr = waddr; bus_s.wbe = wbe; bus_s.wdata = wdata;
      bus_s.raddr_a = ra; bus_s.raddr_b = rb;
   endtask

   task automatic set_we(input logic we);
      bus_m.we = we;
      bus_s.we = we;
   endtask

   // One rising edge; the models take the write that was presented at that edge.
   task automatic step();
      @(posedge clk);
      if (rst && bus_m.we) begin
         for (int b = 0; b < 4; b++) begin
            if (bus_m.wbe[b]) begin
               if (bus_m.waddr != 5'd0) mem_m[bus_m.waddr][8*b +: 8] = bus_m.wdata[8*b +: 8];
               mem_s[bus_m.waddr][8*b +: 8] = bus_m.wdata[8*b +: 8];
            end
         end
      end
      #1;
   endtask

   // ---------------- reference model / scoreboard ----------------
   function automatic logic [31:0] model_read(input bit is_m, input logic [4:0] addr);
      logic [31:0] v;
      if (!rst) return 32'h0;
      if (is_m && addr == 5'd0) return 32'h0;
      v = is_m ? mem_m[addr] : mem_s[addr];
      if (is_m && bus_m.we && addr == bus_m.waddr) begin
         for (int b = 0; b < 4; b++)
            if (bus_m.wbe[b]) v[8*b +: 8] = bus_m.wdata[8*b +: 8];
      end
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%08h exp=%08h", name, got, exp);
      end
   endtask

   task automatic check_model(input string name);
      exp_q.push_back(model_read(1'b1, bus_m.raddr_a));
      exp_q.push_back(model_read(1'b1, bus_m.raddr_b));
      exp_q.push_back(model_read(1'b0, bus_s.raddr_a));
      exp_q.push_back(model_read(1'b0, bus_s.raddr_b));
      check({name, "_m_a"}, bus_m.rdata_a, exp_q.pop_front());
      check({name, "_m_b"}, bus_m.rdata_b, exp_q.pop_front());
      check({name, "_s_a"}, bus_s.rdata_a, exp_q.pop_front());
      check({name, "_s_b"}, bus_s.rdata_b, exp_q.pop_front());
   endtask

   // ---------------- test sequence ----------------
   initial begin
      vecs[0] = '{1'b1, 5'd5,  4'hF, 32'hDEADBEEF, 5'd5,  5'd6,  32'hDEADBEEF, 32'h0, 32'hDEADBEEF, 32'h0};
      vecs[1] = '{1'b1, 5'd7,  4'hF, 32'h11223344, 5'd7,  5'd5,  32'h11223344, 32'hDEADBEEF, 32'h11223344, 32'hDEADBEEF};
      vecs[2] = '{1'b1, 5'd7,  4'h5, 32'hAABBCCDD, 5'd7,  5'd7,  32'h11BB33DD, 32'h11BB33DD, 32'h11BB33DD, 32'h11BB33DD};
      vecs[3] = '{1'b1, 5'd0,  4'hF, 32'hFFFFFFFF, 5'd0,  5'd7,  32'h0, 32'h11BB33DD, 32'hFFFFFFFF, 32'h11BB33DD};
      vecs[4] = '{1'b0, 5'd5,  4'hF, 32'h00000000, 5'd5,  5'd0,  32'hDEADBEEF, 32'h0, 32'hDEADBEEF, 32'hFFFFFFFF};
      vecs[5] = '{1'b1, 5'd5,  4'h0, 32'h12345678, 5'd5,  5'd31, 32'hDEADBEEF, 32'h0, 32'hDEADBEEF, 32'h0};
      vecs[6] = '{1'b1, 5'd31, 4'hA, 32'hCAFEBABE, 5'd31, 5'd5,  32'hCA00BA00, 32'hDEADBEEF, 32'hCA00BA00, 32'hDEADBEEF};
      vecs[7] = '{1'b1, 5'd5,  4'h1, 32'h00000077, 5'd5,  5'd31, 32'hDEADBE77, 32'hCA00BA00, 32'hDEADBE77, 32'hCA00BA00};

      drive(1'b0, 5'd0, 4'h0, 32'h0, 5'd1, 5'd2);
      assert_reset();
      #1;
      check("por_m_a", bus_m.rdata_a, 32'h0);
      check("por_s_b", bus_s.rdata_b, 32'h0);
      repeat (2) @(posedge clk);
      #2 rst = 1'b1;
      step();

      // Table: write through one edge, drop we, then read.
      for (int i = 0; i < 8; i++) begin
         drive(vecs[i].we, vecs[i].waddr, vecs[i].wbe, vecs[i].wdata, vecs[i].ra, vecs[i].rb);
         step();
         set_we(1'b0);
         #1;
         check($sformatf("vec%0d_m_a", i), bus_m.rdata_a, vecs[i].exp_ma);
         check($sformatf("vec%0d_m_b", i), bus_m.rdata_b, vecs[i].exp_mb);
         check($sformatf("vec%0d_s_a", i), bus_s.rdata_a, vecs[i].exp_sa);
         check($sformatf("vec%0d_s_b", i), bus_s.rdata_b, vecs[i].exp_sb);
      end

      // Bypass of a partial write into an empty entry, before and after the edge.
      drive(1'b1, 5'd9, 4'b0011, 32'h12345678, 5'd9, 5'd9);
      #1;
      check("byp_pre_m_a", bus_m.rdata_a, 32'h00005678);
      check("byp_pre_m_b", bus_m.rdata_b, 32'h00005678);
      check("byp_pre_s_a", bus_s.rdata_a, 32'h0);
      step();
      set_we(1'b0);
      #1;
      check("byp_post_m_a", bus_m.rdata_a, 32'h00005678);
      check("byp_post_s_b", bus_s.rdata_b, 32'h00005678);

      // Zero entry must not bypass.
      drive(1'b1, 5'd0, 4'hF, 32'h5A5A5A5A, 5'd0, 5'd9);
      #1;
      check("zero_byp_m_a", bus_m.rdata_a, 32'h0);
      check("zero_byp_s_a", bus_s.rdata_a, 32'hFFFFFFFF);
      step();
      set_we(1'b0);
      #1;
      check("zero_post_m_a", bus_m.rdata_a, 32'h0);
      check("zero_post_s_a", bus_s.rdata_a, 32'h5A5A5A5A);

      // Randomized traffic against the model; read addresses often track the write address.
      for (int n = 0; n < 300; n++) begin
         logic [4:0] wa;
         wa = 5'($urandom_range(0, 31));
         drive(1'($urandom_range(0, 1)), wa, 4'($urandom_range(0, 15)), $urandom(),
               ($urandom_range(0, 1) == 1) ? wa : 5'($urandom_range(0, 31)),
               ($urandom_range(0, 2) == 0) ? wa : 5'($urandom_range(0, 31)));
         #1;
         check_model($sformatf("rnd%0d", n));
         step();
      end

      // Fill every entry so the reset sweep has something to clear.
      for (int i = 0; i < 32; i++) begin
         drive(1'b1, 5'(i), 4'hF, $urandom() | 32'h1, 5'(i), 5'(i));
         step();
      end
      set_we(1'b0);
      #1;
      check_model("filled");
      check("filled_s_a_nz", {31'h0, bus_s.rdata_a != 32'h0}, 32'h1);

      // Reset sweep: zero on every address from the moment rst falls, with a write held.
      assert_reset();
      for (int i = 0; i < 32; i++) begin
         drive(1'b1, 5'(i), 4'hF, 32'hFFFFFFFF, 5'(i), 5'(31 - i));
         #1;
         check_model($sformatf("rstsweep%0d", i));
      end
      @(negedge clk);
      rst = 1'b1;
      set_we(1'b0);
      step();

      // Reset pulse across an edge with a write pending: clear wins, then the write lands.
      drive(1'b1, 5'd3, 4'hF, 32'hCAFEF00D, 5'd3, 5'd3);
      #2;
      assert_reset();
      @(posedge clk);
      #2 rst = 1'b1;
      set_we(1'b0);
      #1;
      check("midrst_m_a", bus_m.rdata_a, 32'h0);
      check("midrst_s_b", bus_s.rdata_b, 32'h0);
      set_we(1'b1);
      step();
      set_we(1'b0);
      #1;
      check("postrst_m_a", bus_m.rdata_a, 32'hCAFEF00D);
      check("postrst_s_b", bus_s.rdata_b, 32'hCAFEF00D);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
